// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: EX/MEM consumer, data-memory req/ack handshake,
// upstream stall generation and registered MEM/WB outputs.
module mem_stage_ctrl #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_to_reg_in,
    input  logic        reg_to_mem_in,
    input  logic [3:0]  reg_rd_in,
    input  logic [15:0] alu_result_in,
    input  logic [15:0] save_word_data_in,
    input  logic        ret_future_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic        wb_valid_out,
    output logic [3:0]  wb_rd_out,
    output logic [15:0] wb_data_out,
    output logic        wb_load_out,
    output logic        ret_wb_out,
    output logic        mem_err_out
);

    localparam int unsigned CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    rd_q;
    logic          ret_q;
    logic          load_q;

    logic mem_op;
    logic illegal_op;
    logic timeout;

    assign mem_op     = mem_to_reg_in ^ reg_to_mem_in;
    assign illegal_op = mem_to_reg_in & reg_to_mem_in;
    assign timeout    = (wait_cnt == CNT_LAST);

    // Stall is masked by reset so the pipeline never freezes on reset noise.
    always_comb begin
        stall_out = 1'b0;
        if (rst_n) begin
            unique case (state)
                S_IDLE:  stall_out = mem_op;
                S_WAIT:  stall_out = !dmem_ack && !timeout;
                default: stall_out = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            rd_q         <= '0;
            ret_q        <= 1'b0;
            load_q       <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wb_valid_out <= 1'b0;
            wb_rd_out    <= '0;
            wb_data_out  <= '0;
            wb_load_out  <= 1'b0;
            ret_wb_out   <= 1'b0;
            mem_err_out  <= 1'b0;
        end else begin
            // Default every cycle to a writeback bubble.
            wb_valid_out <= 1'b0;
            wb_rd_out    <= '0;
            wb_data_out  <= '0;
            wb_load_out  <= 1'b0;
            ret_wb_out   <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        state      <= S_WAIT;
                        wait_cnt   <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= reg_to_mem_in;
                        dmem_addr  <= alu_result_in;
                        dmem_wdata <= save_word_data_in;
                        rd_q       <= reg_rd_in;
                        ret_q      <= ret_future_in;
                        load_q     <= mem_to_reg_in;
                    end else if (illegal_op) begin
                        mem_err_out <= 1'b1;
                    end else begin
                        wb_valid_out <= 1'b1;
                        wb_rd_out    <= reg_rd_in;
                        wb_data_out  <= alu_result_in;
                        ret_wb_out   <= ret_future_in;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        state      <= S_IDLE;
                        wait_cnt   <= '0;
                        dmem_req   <= 1'b0;
                        ret_wb_out <= ret_q;
                        if (load_q) begin
                            wb_valid_out <= 1'b1;
                            wb_rd_out    <= rd_q;
                            wb_data_out  <= dmem_rdata;
                            wb_load_out  <= 1'b1;
                        end
                    end else if (timeout) begin
                        state       <= S_IDLE;
                        wait_cnt    <= '0;
                        dmem_req    <= 1'b0;
                        mem_err_out <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
